// File: rtl/fifo_pkg.sv
// Constants and pointer helpers shared by the read and write sides of the 8-entry FIFO.
package fifo_pkg;

   localparam int FIFO_DEPTH = 8;
   localparam int FIFO_PTR_W = 4;

   // Full when the index bits match but the wrap bits differ.
   function automatic logic ptr_full(input logic [FIFO_PTR_W-1:0] wp,
                                     input logic [FIFO_PTR_W-1:0] rp);
      return (wp[FIFO_PTR_W-2:0] == rp[FIFO_PTR_W-2:0]) &&
             (wp[FIFO_PTR_W-1] != rp[FIFO_PTR_W-1]);
   endfunction

   function automatic logic [FIFO_PTR_W-1:0] ptr_count(input logic [FIFO_PTR_W-1:0] wp,
                                                       input logic [FIFO_PTR_W-1:0] rp);
      return wp - rp;
   endfunction

endpackage

// File: rtl/fifo_wr_dec_3_8.sv
// One-hot 3-to-8 decoder producing per-entry load enables, gated by the accepted write.
module fifo_wr_dec_3_8
   import fifo_pkg::*;
(
   input  logic                  en,
   input  logic [2:0]            sel,
   output logic [FIFO_DEPTH-1:0] ld
);

   // Decode the entry index into a single load enable when a write is accepted.
   always_comb begin
      ld = 8'b0000_0000;
      if (en) begin
         ld = 8'b0000_0001 << sel;
      end else begin
         ld = 8'b0000_0000;
      end
   end

endmodule

// File: rtl/fifo_wr_demux_8.sv
// Write side of an 8-entry FIFO: pointer, entry registers, full/count status.
// Optional sticky overflow output when FIFO_WR_OVERFLOW_FLAG_EN is defined.
module fifo_wr_demux_8
   import fifo_pkg::*;
#(
   parameter int bw = 4,
   parameter int br = 1
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic [br*bw-1:0]      in,
   input  logic [FIFO_PTR_W-1:0] rd_ptr,
   output logic [FIFO_PTR_W-1:0] wr_ptr,
   output logic [br*bw-1:0]      q0,
   output logic [br*bw-1:0]      q1,
   output logic [br*bw-1:0]      q2,
   output logic [br*bw-1:0]      q3,
   output logic [br*bw-1:0]      q4,
   output logic [br*bw-1:0]      q5,
   output logic [br*bw-1:0]      q6,
   output logic [br*bw-1:0]      q7,
   output logic                  full,
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
   output logic                  overflow,
`endif
   output logic [FIFO_PTR_W-1:0] count
);

   localparam int W = br * bw;

   logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [W-1:0]          entry_q [FIFO_DEPTH];
   logic [W-1:0]          entry_d [FIFO_DEPTH];
   logic                  accept_s;
   logic [FIFO_DEPTH-1:0] ld_s;

   assign full     = ptr_full(wr_ptr_q, rd_ptr);
   assign count    = ptr_count(wr_ptr_q, rd_ptr);
   assign accept_s = wr & ~full;

   fifo_wr_dec_3_8 u_dec (
      .en  (accept_s),
      .sel (wr_ptr_q[2:0]),
      .ld  (ld_s)
   );

   // Next pointer and next entry contents; only the decoded entry loads.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      for (int i = 0; i < FIFO_DEPTH; i++) entry_d[i] = entry_q[i];
      if (accept_s) begin
         wr_ptr_d = wr_ptr_q + 4'd1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (ld_s[i]) begin
            entry_d[i] = in;
         end else begin
            entry_d[i] = entry_q[i];
         end
      end
   end

   // Pointer and entry registers, cleared immediately by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= 4'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) entry_q[i] <= {W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         for (int i = 0; i < FIFO_DEPTH; i++) entry_q[i] <= entry_d[i];
      end
   end

`ifdef FIFO_WR_OVERFLOW_FLAG_EN
   logic overflow_q, overflow_d;

   // Sticky: any write attempt against a full FIFO latches until reset.
   always_comb begin
      overflow_d = overflow_q;
      if (wr && full) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`endif

   assign wr_ptr = wr_ptr_q;
   assign q0 = entry_q[0];
   assign q1 = entry_q[1];
   assign q2 = entry_q[2];
   assign q3 = entry_q[3];
   assign q4 = entry_q[4];
   assign q5 = entry_q[5];
   assign q6 = entry_q[6];
   assign q7 = entry_q[7];

endmodule

// File: tb/tb_fifo_wr_demux_8.sv
// Directed bench for fifo_wr_demux_8 with hand-computed expectations.
module tb_fifo_wr_demux_8;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr;
   logic [3:0] in;
   logic [3:0] rd_ptr;
   logic [3:0] wr_ptr;
   logic [3:0] q0, q1, q2, q3, q4, q5, q6, q7;
   logic       full;
   logic [3:0] count;
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
   logic       overflow;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_wr_demux_8 #(.bw(4), .br(1)) dut (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr),
      .in     (in),
      .rd_ptr (rd_ptr),
      .wr_ptr (wr_ptr),
      .q0 (q0), .q1 (q1), .q2 (q2), .q3 (q3),
      .q4 (q4), .q5 (q5), .q6 (q6), .q7 (q7),
      .full   (full),
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
      .overflow (overflow),
`endif
      .count  (count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [3:0] d);
      wr = 1'b1;
      in = d;
      tick();
      wr = 1'b0;
   endtask

   task automatic chk_q(input string tag, input logic [31:0] exp_all);
      chk({tag, "_q"}, {q7, q6, q5, q4, q3, q2, q1, q0}, exp_all);
   endtask

   initial begin
      reset = 1'b1; wr = 1'b0; in = 4'h0; rd_ptr = 4'd0;
      tick();
      chk("rst_wr_ptr", wr_ptr, 32'd0);
      chk_q("rst", 32'h0000_0000);
      chk("rst_full", full, 32'd0);
      chk("rst_count", count, 32'd0);
      reset = 1'b0;
      tick();

      // three writes
      write(4'h1); write(4'h2); write(4'h3);
      chk_q("w3", 32'h0000_0321);
      chk("w3_wr_ptr", wr_ptr, 32'd3);
      chk("w3_count", count, 32'd3);
      chk("w3_full", full, 32'd0);

      // fill to 8
      write(4'h4); write(4'h5); write(4'h6); write(4'h7); write(4'h8);
      chk_q("w8", 32'h8765_4321);
      chk("w8_wr_ptr", wr_ptr, 32'd8);
      chk("w8_full", full, 32'd1);
      chk("w8_count", count, 32'd8);

      // write while full is ignored
      write(4'hF);
      chk_q("ovf", 32'h8765_4321);
      chk("ovf_wr_ptr", wr_ptr, 32'd8);
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
      chk("ovf_flag", overflow, 32'd1);
`endif

      // read side frees one slot
      rd_ptr = 4'd1;
      #1;
      chk("rd1_full", full, 32'd0);
      chk("rd1_count", count, 32'd7);
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
      chk("ovf_sticky", overflow, 32'd1);
`endif
      write(4'hA);
      chk_q("wA", 32'h8765_432A);
      chk("wA_wr_ptr", wr_ptr, 32'd9);
      chk("wA_full", full, 32'd1);
      chk("wA_count", count, 32'd8);

      // advance to wr_ptr=15 with rd_ptr=8, then wrap
      rd_ptr = 4'd8;
      #1;
      chk("rd8_count", count, 32'd1);
      write(4'hB); write(4'hC); write(4'hD); write(4'hE); write(4'h9); write(4'h6);
      chk("p15_wr_ptr", wr_ptr, 32'd15);
      chk("p15_count", count, 32'd7);
      chk("p15_full", full, 32'd0);
      write(4'h5);
      chk_q("wrap", 32'h569E_DCBA);
      chk("wrap_wr_ptr", wr_ptr, 32'd0);
      chk("wrap_count", count, 32'd8);
      chk("wrap_full", full, 32'd1);

      // read advance on the same edge as a write
      rd_ptr = 4'd9;
      #1;
      chk("rd9_full", full, 32'd0);
      wr = 1'b1; in = 4'h7; rd_ptr = 4'd9;
      @(posedge clk);
      rd_ptr = 4'd10;
      #1;
      wr = 1'b0;
      chk_q("simul", 32'h569E_DCB7);
      chk("simul_wr_ptr", wr_ptr, 32'd1);
      chk("simul_count", count, 32'd7);
      chk("simul_full", full, 32'd0);

      // asynchronous reset mid-cycle with a write pending
      rd_ptr = 4'd0;
      wr = 1'b1; in = 4'hC;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_wr_ptr", wr_ptr, 32'd0);
      chk_q("arst", 32'h0000_0000);
      chk("arst_count", count, 32'd0);
      chk("arst_full", full, 32'd0);
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
      chk("arst_ovf", overflow, 32'd0);
`endif
      tick();
      chk("arst_hold_wr_ptr", wr_ptr, 32'd0);
      chk_q("arst_hold", 32'h0000_0000);
      wr = 1'b0;
      reset = 1'b0;
      tick();
      write(4'h9);
      chk_q("post_rst", 32'h0000_0009);
      chk("post_rst_wr_ptr", wr_ptr, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
